// File: rtl/pio_pkg.sv
// Shared constants for the pio_gpio PIO slave: register map, edge-type codes
// and the synchroniser warm-up length.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int WARM_CYCLES = 3;

  typedef logic [1:0] warm_t;

endpackage

// File: rtl/pio_edge_detect.sv
// Two-flop input synchroniser plus a history flop; flags per-bit edges of the
// selected type between the synchronised value and its previous sample.
module pio_edge_detect
  import pio_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_o = ~sync2_q & prev_q;
      EDGE_ANY:  edge_o = sync2_q ^ prev_q;
      default:   edge_o = sync2_q & ~prev_q;
    endcase
  end

  assign sync_o = sync2_q;

endmodule

// File: rtl/pio_gpio.sv
// Avalon-MM general-purpose PIO: data/direction/mask/edge-capture registers,
// level irq. Define PIO_SETCLR_EN to enable the OUTSET (4) / OUTCLR (5) ports.
module pio_gpio
  import pio_pkg::*;
#(
  parameter int          WIDTH     = 18,
  parameter logic [31:0] OUT_RESET = 32'h0000_0000,
  parameter logic [31:0] DIR_RESET = 32'hFFFF_FFFF,
  parameter int          EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  warm_t            warm_q, warm_d;
  logic [WIDTH-1:0] sync2, edges, clr;
  logic             wr, warm_done;

  pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (in_port),
    .sync_o  (sync2),
    .edge_o  (edges)
  );

  assign wr        = chipselect & ~write_n;
  // Capture stays off until the zeroed synchroniser has filled with real pin data.
  assign warm_done = (warm_q == warm_t'(WARM_CYCLES));
  assign warm_d    = warm_done ? warm_q : warm_q + warm_t'(1);

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    clr        = '0;
    if (wr) begin
      case (address)
        ADDR_DATA: data_out_d = writedata;
        ADDR_DIR:  dir_d      = writedata;
        ADDR_MASK: mask_d     = writedata;
        ADDR_EDGE: clr        = writedata;
`ifdef PIO_SETCLR_EN
        ADDR_SET:  data_out_d = data_out_q | writedata;
        ADDR_CLR:  data_out_d = data_out_q & ~writedata;
`endif
        default: ;
      endcase
    end
    // A new edge beats a simultaneous write-1-clear of the same bit.
    cap_d = (cap_q & ~clr) | (warm_done ? edges : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q <= OUT_RESET[WIDTH-1:0];
      dir_q      <= DIR_RESET[WIDTH-1:0];
      mask_q     <= '0;
      cap_q      <= '0;
      warm_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      warm_q     <= warm_d;
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA: readdata = (dir_q & data_out_q) | (~dir_q & sync2);
      ADDR_DIR:  readdata = dir_q;
      ADDR_MASK: readdata = mask_q;
      ADDR_EDGE: readdata = cap_q;
      ADDR_SET,
      ADDR_CLR:  readdata = '0;
      default:   readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio.sv
// Self-checking bench for pio_gpio (default parameters); honours PIO_SETCLR_EN.
module tb_pio_gpio;

  localparam int W = 18;
  localparam logic [W-1:0] ALL1 = 18'h3FFFF;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] readdata;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] out_port;
  logic [W-1:0] oe;
  logic         irq;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  pio_gpio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pins sampled at edge j are samp[j]; after edge n the
  // synchronised value is samp[n-1]; capture compares the pin history two and
  // three edges back and is allowed from the fourth edge after reset.
  logic [W-1:0] samp [0:4095];
  int           n = 0;
  logic [W-1:0] m_out = '0, m_dir = ALL1, m_mask = '0, m_cap = '0;

  function automatic logic [W-1:0] pin_at(int j);
    if (j < 1 || j > 4095) return '0;
    return samp[j];
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] s, p, e, clrv;
    if (!reset_n) begin
      n = 0; m_out = '0; m_dir = ALL1; m_mask = '0; m_cap = '0;
    end else begin
      n = n + 1;
      if (n <= 4095) samp[n] = in_port;
      s = pin_at(n - 2);
      p = pin_at(n - 3);
      e = s & ~p;
      clrv = '0;
      if (chipselect && !write_n) begin
        if (address == 3'd0) m_out = writedata;
        if (address == 3'd1) m_dir = writedata;
        if (address == 3'd2) m_mask = writedata;
        if (address == 3'd3) clrv = writedata;
`ifdef PIO_SETCLR_EN
        if (address == 3'd4) m_out = m_out | writedata;
        if (address == 3'd5) m_out = m_out & ~writedata;
`endif
      end
      m_cap = (m_cap & ~clrv) | ((n >= 4) ? e : '0);
    end
  end

  function automatic logic [W-1:0] model_read(logic [2:0] a);
    case (a)
      3'd0: return (m_dir & m_out) | (~m_dir & pin_at(n - 1));
      3'd1: return m_dir;
      3'd2: return m_mask;
      3'd3: return m_cap;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_port", out_port, m_out);
      chk("cyc_oe", oe, m_dir);
      chk("cyc_irq", W'(irq), W'(|(m_cap & m_mask)));
      chk("cyc_readdata", readdata, model_read(address));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [W-1:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [W-1:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    ticks(2);
    chk_en = 1'b1;
    reset_n = 1'b1;
    chk("rst_out_port", out_port, 18'h00000);
    chk("rst_oe", oe, 18'h3FFFF);
    chk("rst_irq", W'(irq), 18'h0);
    rd_chk("rst_edge_cap", 3'd3, 18'h00000);

    wr_reg(3'd0, 18'h2A5A5);
    chk("data_out_port", out_port, 18'h2A5A5);
    rd_chk("data_read", 3'd0, 18'h2A5A5);

    // Input path latency with all bits as inputs.
    wr_reg(3'd1, 18'h00000);
    in_port = 18'h00F0F;
    rd_chk("in_before_k", 3'd0, 18'h00000);
    tick();
    rd_chk("in_after_k", 3'd0, 18'h00000);
    tick();
    rd_chk("in_after_k1", 3'd0, 18'h00F0F);

    // Rising-edge capture on bit0 with irq.
    in_port = 18'h00000;
    ticks(4);
    wr_reg(3'd3, ALL1);
    rd_chk("cap_cleared", 3'd3, 18'h00000);
    wr_reg(3'd2, 18'h00001);
    ticks(2);
    in_port = 18'h00001;
    tick();
    rd_chk("cap_at_k", 3'd3, 18'h00000);
    tick();
    rd_chk("cap_at_k1", 3'd3, 18'h00000);
    chk("irq_at_k1", W'(irq), 18'h0);
    tick();
    rd_chk("cap_at_k2", 3'd3, 18'h00001);
    chk("irq_at_k2", W'(irq), 18'h1);
    wr_reg(3'd3, 18'h00001);
    chk("irq_cleared", W'(irq), 18'h0);

    // New edge and write-1-clear on the same edge: set wins.
    in_port = 18'h00000;
    ticks(4);
    in_port = 18'h00001;
    ticks(2);
    wr_reg(3'd3, 18'h00001);
    rd_chk("set_beats_clr", 3'd3, 18'h00001);
    chk("set_beats_clr_irq", W'(irq), 18'h1);
    wr_reg(3'd3, 18'h00001);

    // Pins high through reset release: warm-up hides the synchroniser fill.
    in_port = ALL1;
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(8);
    rd_chk("warm_suppress", 3'd3, 18'h00000);
    chk("warm_irq", W'(irq), 18'h0);

    // Set/clear ports (reserved when the feature is off).
    wr_reg(3'd0, 18'h00F00);
    wr_reg(3'd4, 18'h0000F);
`ifdef PIO_SETCLR_EN
    rd_chk("outset", 3'd0, 18'h00F0F);
`else
    rd_chk("outset", 3'd0, 18'h00F00);
`endif
    wr_reg(3'd5, 18'h00F00);
`ifdef PIO_SETCLR_EN
    rd_chk("outclr", 3'd0, 18'h0000F);
`else
    rd_chk("outclr", 3'd0, 18'h00F00);
`endif
    rd_chk("read_addr4", 3'd4, 18'h00000);
    wr_reg(3'd6, 18'h12345);
    rd_chk("read_addr6", 3'd6, 18'h00000);
    rd_chk("dir_intact", 3'd1, 18'h3FFFF);

    // Reset beats a simultaneous write.
    address = 3'd0; writedata = 18'h15555; chipselect = 1'b1; write_n = 1'b0;
    reset_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    chk("rst_over_write", out_port, 18'h00000);
    ticks(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
